control_issue_queue: RTL and testbench

CONTROL_ISSUE_QUEUE -- requirements
Module: control_issue_queue

---
 rtl/control_issue_queue.sv | 99 +++++++++
 tb/tb_control_issue_queue.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/control_issue_queue.sv
// control_issue_queue: in-order FIFO of decoded control bundles between decode and execute.
// Ports:
//   clock, reset           single clock, asynchronous active-high reset
//   in_valid/in_ready      decode-side handshake; in_pc/in_ctrl is the offered bundle
//   out_valid/out_ready    execute-side handshake; out_pc/out_ctrl is the head entry (fall-through)
//   mem_busy               data memory cannot take a new access; blocks a memory-op head
//   flush                  discards all entries at the rising edge
//   count                  occupancy, 0..DEPTH
//   report                 enables a per-cycle state printout
module control_issue_queue #(
    parameter int CORE  = 0,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [15:0]              in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [15:0]              out_ctrl,
    input  logic                     mem_busy,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     report
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   pc_d   [DEPTH];
    logic [15:0]   ctrl_q [DEPTH];
    logic [15:0]   ctrl_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   cyc_q, cyc_d;
    logic          head_mem, push, pop;

    assign in_ready  = cnt_q < CW'(DEPTH);
    assign out_pc    = pc_q[rp_q];
    assign out_ctrl  = ctrl_q[rp_q];
    assign count     = cnt_q;
    // memRead or memWrite at the head stalls the whole queue while memory is busy
    assign head_mem  = out_ctrl[1] | out_ctrl[6];
    assign out_valid = (cnt_q != '0) && !flush && !(head_mem && mem_busy);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        pc_d   = pc_q;
        ctrl_d = ctrl_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        cyc_d  = cyc_q + 32'd1;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                pc_d[wp_q]   = in_pc;
                ctrl_d[wp_q] = in_ctrl;
                wp_d         = wp_q + AW'(1);
            end
            if (pop) rp_d = rp_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                ctrl_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            cyc_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ctrl_q <= ctrl_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            cyc_q  <= cyc_d;
        end
    end

    // Observation only; ignored by synthesis semantics and has no effect on state.
    always @(posedge clock) begin
        if (report && !reset)
            $display("core %0d cycle %0d count %0d wp %0d rp %0d head_pc %h head_ctrl %h out_valid %0b",
                     CORE, cyc_q, cnt_q, wp_q, rp_q, out_pc, out_ctrl, out_valid);
    end
endmodule

// File: tb/tb_control_issue_queue.sv
// tb_control_issue_queue: directed self-checking bench for control_issue_queue.
module tb_control_issue_queue;
    logic        clock = 0;
    logic        reset = 1;
    logic        in_valid = 0, out_ready = 0, mem_busy = 0, flush = 0, report = 0;
    logic [31:0] in_pc = 0;
    logic [15:0] in_ctrl = 0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc;
    logic [15:0] out_ctrl;
    logic [2:0]  count;
    int checks = 0;
    int errors = 0;

    control_issue_queue #(.CORE(0), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ctrl(out_ctrl), .mem_busy(mem_busy), .flush(flush),
        .count(count), .report(report)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
        checks++; if (out_ctrl !== 16'h0) begin errors++; $display("FAIL reset_out_ctrl got %h exp 0", out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        @(negedge clock);
        reset = 0;
        tick();
    endtask

    task automatic test_fill_drain();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_pc = 32'h100 + 32'(4 * i); in_ctrl = 16'h8020 + 16'(i);
            tick();
        end
        in_pc = 32'h500; in_ctrl = 16'h0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
        tick();
        in_valid = 0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fifth_push_count got %0d exp 4", count); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i) || out_ctrl !== 16'h8020 + 16'(i)) begin
                errors++; $display("FAIL drain_head%0d got v=%b pc=%h ctrl=%h exp v=1 pc=%h ctrl=%h",
                                   i, out_valid, out_pc, out_ctrl, 32'h100 + 32'(4 * i), 16'h8020 + 16'(i));
            end
            tick();
            checks++; if (count !== 3'(3 - i)) begin errors++; $display("FAIL drain_count%0d got %0d exp %0d", i, count, 3 - i); end
        end
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_simultaneous();
        in_valid = 1; in_ctrl = 16'h4000;
        in_pc = 32'h1F0; tick();
        in_pc = 32'h1F4; tick();
        in_pc = 32'h200; out_ready = 1;
        checks++; if (out_pc !== 32'h1F0) begin errors++; $display("FAIL simul_head got %h exp 1f0", out_pc); end
        tick();
        in_valid = 0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count got %0d exp 2", count); end
        checks++; if (out_pc !== 32'h1F4) begin errors++; $display("FAIL simul_second got %h exp 1f4", out_pc); end
        tick();
        checks++; if (out_pc !== 32'h200 || out_valid !== 1'b1) begin errors++; $display("FAIL simul_third got v=%b pc=%h exp v=1 pc=200", out_valid, out_pc); end
        tick();
        out_ready = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL simul_empty got %0d exp 0", count); end
        in_valid = 1; in_pc = 32'h400; tick();
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_pc = 32'h404 + 32'(4 * i);
            checks++; if (out_pc !== 32'h400 + 32'(4 * i)) begin errors++; $display("FAIL wrap_head%0d got %h exp %h", i, out_pc, 32'h400 + 32'(4 * i)); end
            tick();
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count%0d got %0d exp 1", i, count); end
        end
        in_valid = 0;
        checks++; if (out_pc !== 32'h428) begin errors++; $display("FAIL wrap_last got %h exp 428", out_pc); end
        tick();
        out_ready = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_empty got %0d exp 0", count); end
    endtask

    task automatic test_mem_block();
        mem_busy = 1; out_ready = 0;
        in_valid = 1; in_pc = 32'h600; in_ctrl = 16'h4016; tick();
        in_pc = 32'h604; in_ctrl = 16'h4000; tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL memblk_valid got %b exp 0", out_valid); end
        out_ready = 1; tick();
        checks++; if (count !== 3'd2 || out_pc !== 32'h600) begin errors++; $display("FAIL memblk_hold got cnt=%0d pc=%h exp cnt=2 pc=600", count, out_pc); end
        out_ready = 0; mem_busy = 0; tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 16'h4016) begin errors++; $display("FAIL memfree_valid got v=%b ctrl=%h exp v=1 ctrl=4016", out_valid, out_ctrl); end
        out_ready = 1; tick();
        out_ready = 0; mem_busy = 1; #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h604) begin errors++; $display("FAIL nonmem_issue got v=%b pc=%h exp v=1 pc=604", out_valid, out_pc); end
        out_ready = 1; tick();
        out_ready = 0; mem_busy = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mem_empty got %0d exp 0", count); end
    endtask

    task automatic test_flush();
        in_valid = 1; in_ctrl = 16'h0;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h700 + 32'(4 * i); tick();
        end
        in_pc = 32'h7F0; out_ready = 1; flush = 1; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_comb got %b exp 0", out_valid); end
        tick();
        flush = 0; in_valid = 0; out_ready = 0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_state got cnt=%0d v=%b exp cnt=0 v=0", count, out_valid); end
        checks++; if (out_pc !== 32'h700) begin errors++; $display("FAIL flush_storage got %h exp 700", out_pc); end
        in_valid = 1; in_pc = 32'h720; tick();
        in_valid = 0;
        checks++; if (count !== 3'd1 || out_pc !== 32'h720) begin errors++; $display("FAIL post_flush_push got cnt=%0d pc=%h exp cnt=1 pc=720", count, out_pc); end
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_async_reset();
        in_valid = 1; in_ctrl = 16'h0;
        in_pc = 32'h800; tick();
        in_pc = 32'h804; tick();
        in_valid = 0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pre_reset_count got %0d exp 2", count); end
        #2 reset = 1;
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset got cnt=%0d v=%b pc=%h rdy=%b exp cnt=0 v=0 pc=0 rdy=1", count, out_valid, out_pc, in_ready);
        end
        #1 reset = 0;
        in_valid = 1; in_pc = 32'h300; in_ctrl = 16'h4000; tick();
        in_valid = 0;
        checks++; if (out_pc !== 32'h300 || out_valid !== 1'b1 || count !== 3'd1) begin
            errors++; $display("FAIL post_reset_push got pc=%h v=%b cnt=%0d exp pc=300 v=1 cnt=1", out_pc, out_valid, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_mem_block();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
